itch_msg_assembler: RTL and testbench

- Upstream stage of the ITCH decoders. Takes a length-prefixed ITCH byte stream (2-byte big-endian length, then the message body) and packs each body into a left-aligned 512-bit payload.
- Emits a one-cycle payload strobe for every message. Also emits a separate add-order strobe for type 'A' messages, which drives the valid/payload inputs of the add-order decoder directly.

---
 rtl/itch_msg_assembler_if.sv | 28 ++
 rtl/itch_msg_assembler.sv | 149 ++++++++++++++
 tb/tb_itch_msg_assembler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/itch_msg_assembler_if.sv
// Stream-in / message-out bundle between the ITCH byte source, the assembler
// and the downstream decoders.
interface itch_msg_assembler_if #(
  parameter int MAX_BYTES = 64
);
  logic                   in_valid;
  logic [7:0]             in_byte;
  logic [8*MAX_BYTES-1:0] payload;
  logic                   payload_valid;
  logic [7:0]             msg_type;
  logic [15:0]            msg_len;
  logic                   add_order_valid;
  logic                   truncated;
  logic                   len_err;
  logic [31:0]            msg_count;

  modport master (
    output in_valid, in_byte,
    input  payload, payload_valid, msg_type, msg_len,
    input  add_order_valid, truncated, len_err, msg_count
  );

  modport slave (
    input  in_valid, in_byte,
    output payload, payload_valid, msg_type, msg_len,
    output add_order_valid, truncated, len_err, msg_count
  );
endinterface

// File: rtl/itch_msg_assembler.sv
// Packs length-prefixed ITCH messages into a left-aligned payload and strobes
// them out; optional add-order length check enabled by ITCH_LEN_CHECK_EN.
module itch_msg_assembler #(
  parameter int         MAX_BYTES      = 64,
  parameter logic [7:0] ADD_ORDER_TYPE = 8'h41,
  parameter int         ADD_ORDER_LEN  = 36
) (
  input logic                  clk,
  input logic                  rst,
  itch_msg_assembler_if.slave  bus
);
  localparam int          PW      = 8 * MAX_BYTES;
  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);
  localparam logic [15:0] AO_LEN  = 16'(ADD_ORDER_LEN);
`ifdef ITCH_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {LEN_HI, LEN_LO, BODY} state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [PW-1:0] buf_q, buf_d;
  logic          done;

  logic [PW-1:0] payload_q, payload_d;
  logic [7:0]    msg_type_q, msg_type_d;
  logic [15:0]   msg_len_q, msg_len_d;
  logic          trunc_q, trunc_d;
  logic          pv_q, pv_d;
  logic          aov_q, aov_d;
  logic          lerr_q, lerr_d;
  logic [31:0]   msg_cnt_q, msg_cnt_d;

  logic [7:0]    type_now;
  logic          trunc_now;
  logic          len_ok;
  logic          is_add;

  // Frame parser: length prefix, then body bytes into the staging buffer.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    done    = 1'b0;
    case (state_q)
      LEN_HI: begin
        if (bus.in_valid) begin
          len_d   = {bus.in_byte, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (bus.in_valid) begin
          len_d = {len_q[15:8], bus.in_byte};
          if (len_d != 16'd0) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = BODY;
          end else begin
            state_d = LEN_HI;
          end
        end
      end
      BODY: begin
        if (bus.in_valid) begin
          for (int i = 0; i < MAX_BYTES; i++) begin
            if (cnt_q == 16'(i)) buf_d[PW-1-8*i -: 8] = bus.in_byte;
          end
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == len_q) begin
            done    = 1'b1;
            state_d = LEN_HI;
          end
        end
      end
      default: state_d = LEN_HI;
    endcase
  end

  // Output stage: captured only at message end so decoders see a stable word.
  always_comb begin
    type_now   = buf_d[PW-1 -: 8];
    trunc_now  = (len_q > MAX_LEN);
    len_ok     = !LEN_CHECK || (len_q == AO_LEN);
    is_add     = (type_now == ADD_ORDER_TYPE);
    payload_d  = payload_q;
    msg_type_d = msg_type_q;
    msg_len_d  = msg_len_q;
    trunc_d    = trunc_q;
    msg_cnt_d  = msg_cnt_q;
    pv_d       = 1'b0;
    aov_d      = 1'b0;
    lerr_d     = 1'b0;
    if (done) begin
      payload_d  = buf_d;
      msg_type_d = type_now;
      msg_len_d  = len_q;
      trunc_d    = trunc_now;
      msg_cnt_d  = msg_cnt_q + 32'd1;
      pv_d       = 1'b1;
      aov_d      = is_add && !trunc_now && len_ok;
      lerr_d     = is_add && !len_ok;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (rst) begin
      state_q    <= LEN_HI;
      len_q      <= '0;
      cnt_q      <= '0;
      payload_q  <= '0;
      msg_type_q <= '0;
      msg_len_q  <= '0;
      trunc_q    <= 1'b0;
      pv_q       <= 1'b0;
      aov_q      <= 1'b0;
      lerr_q     <= 1'b0;
      msg_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      msg_type_q <= msg_type_d;
      msg_len_q  <= msg_len_d;
      trunc_q    <= trunc_d;
      pv_q       <= pv_d;
      aov_q      <= aov_d;
      lerr_q     <= lerr_d;
      msg_cnt_q  <= msg_cnt_d;
    end
  end

  assign bus.payload         = payload_q;
  assign bus.payload_valid   = pv_q;
  assign bus.msg_type        = msg_type_q;
  assign bus.msg_len         = msg_len_q;
  assign bus.truncated       = trunc_q;
  assign bus.add_order_valid = aov_q;
  assign bus.len_err         = lerr_q;
  assign bus.msg_count       = msg_cnt_q;

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Directed bench for itch_msg_assembler: message-level reference model plus
// hand-computed spot values.
module tb_itch_msg_assembler;
`ifdef ITCH_LEN_CHECK_EN
  localparam bit LCHK = 1'b1;
`else
  localparam bit LCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itch_msg_assembler_if #(.MAX_BYTES(64)) bus ();

  itch_msg_assembler #(
    .MAX_BYTES(64), .ADD_ORDER_TYPE(8'h41), .ADD_ORDER_LEN(36)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int           cyc;
    logic [511:0] payload;
    logic [7:0]   typ;
    logic [15:0]  len;
    logic         trunc;
    logic         aov;
    logic         lerr;
  } exp_t;

  exp_t         q[$];
  logic [7:0]   body [0:127];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;

  logic [511:0] m_payload = '0;
  logic [7:0]   m_type = '0;
  logic [15:0]  m_len = '0;
  logic         m_trunc = 1'b0, m_pv = 1'b0, m_aov = 1'b0, m_lerr = 1'b0;
  logic [31:0]  m_count = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outcome of one complete message, straight from the message rules.
  function automatic exp_t model_msg(input int len, input int at);
    exp_t r;
    r.cyc     = at;
    r.payload = '0;
    for (int i = 0; i < len && i < 64; i++) r.payload[511-8*i -: 8] = body[i];
    r.typ   = body[0];
    r.len   = 16'(len);
    r.trunc = (len > 64);
    r.aov   = (body[0] == 8'h41) && !r.trunc && (!LCHK || len == 36);
    r.lerr  = LCHK && (body[0] == 8'h41) && (len != 36);
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      m_payload = '0; m_type = '0; m_len = '0; m_trunc = 1'b0;
      m_pv = 1'b0; m_aov = 1'b0; m_lerr = 1'b0; m_count = '0;
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t r;
      r = q.pop_front();
      m_payload = r.payload; m_type = r.typ; m_len = r.len; m_trunc = r.trunc;
      m_pv = 1'b1; m_aov = r.aov; m_lerr = r.lerr; m_count = m_count + 32'd1;
    end else begin
      m_pv = 1'b0; m_aov = 1'b0; m_lerr = 1'b0;
    end
    chk("payload_valid", bus.payload_valid, m_pv);
    chk("add_order_valid", bus.add_order_valid, m_aov);
    chk("len_err", bus.len_err, m_lerr);
    chk("payload", bus.payload, m_payload);
    chk("msg_type", bus.msg_type, m_type);
    chk("msg_len", bus.msg_len, m_len);
    chk("truncated", bus.truncated, m_trunc);
    chk("msg_count", bus.msg_count, m_count);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
    end
  endtask

  task automatic send_msg(input int len, input int g0, input int g1, input int g2);
    send_byte(8'(len >> 8));
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      send_byte(body[i]);
      if (i == len - 1) q.push_back(model_msg(len, cyc + 1));
      if (i == g0 || i == g1 || i == g2) idle(3);
    end
  endtask

  task automatic fill_add_order();
    for (int i = 0; i < 36; i++) body[i] = 8'(8'h10 + 3 * i);
    body[0] = 8'h41;
    for (int i = 1; i <= 8; i++) body[i] = 8'(i);
    body[9]  = 8'h53;
    body[10] = 8'h00; body[11] = 8'h00; body[12] = 8'h00; body[13] = 8'h64;
    body[18] = 8'h00; body[19] = 8'h0F; body[20] = 8'h42; body[21] = 8'h40;
  endtask

  task automatic fill_pattern(input logic [7:0] typ, input int len, input int seed);
    for (int i = 0; i < len; i++) body[i] = 8'(seed + 7 * i);
    body[0] = typ;
  endtask

  initial begin
    logic [511:0] one_byte;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_payload", bus.payload, '0);
    chk("rst_count", bus.msg_count, 32'd0);
    chk("rst_pv", bus.payload_valid, 1'b0);
    @(negedge clk) rst = 1'b0;
    idle(2);

    // Add order, no gaps
    fill_add_order();
    send_msg(36, -1, -1, -1);
    @(posedge clk); #2;
    chk("t1_pv", bus.payload_valid, 1'b1);
    chk("t1_aov", bus.add_order_valid, 1'b1);
    chk("t1_type", bus.msg_type, 8'h41);
    chk("t1_len", bus.msg_len, 16'd36);
    chk("t1_tail_zero", bus.payload[223:0], '0);
    chk("t1_order_ref", bus.payload[503 -: 64], 64'h0102030405060708);
    chk("t1_side", bus.payload[439 -: 8], 8'h53);
    chk("t1_shares", bus.payload[431 -: 32], 32'h00000064);
    chk("t1_price", bus.payload[367 -: 32], 32'h000F4240);
    chk("t1_count", bus.msg_count, 32'd1);
    idle(2);

    // Same message with gaps, including after the final byte
    send_msg(36, 0, 10, 35);
    chk("t2_pv_after_gap", bus.payload_valid, 1'b0);
    idle(2);
    chk("t2_count", bus.msg_count, 32'd2);
    chk("t2_price", bus.payload[367 -: 32], 32'h000F4240);

    // 'E' then add order, back-to-back
    fill_pattern(8'h45, 12, 3);
    send_msg(12, -1, -1, -1);
    fill_add_order();
    send_msg(36, -1, -1, -1);
    @(posedge clk); #2;
    chk("t3_aov", bus.add_order_valid, 1'b1);
    chk("t3_count", bus.msg_count, 32'd4);
    idle(2);

    // Oversized add order, then a normal one
    fill_pattern(8'h41, 80, 9);
    send_msg(80, -1, -1, -1);
    @(posedge clk); #2;
    chk("t4_trunc", bus.truncated, 1'b1);
    chk("t4_aov", bus.add_order_valid, 1'b0);
    chk("t4_len", bus.msg_len, 16'd80);
    fill_add_order();
    send_msg(36, -1, -1, -1);
    idle(2);
    chk("t4_trunc_clr", bus.truncated, 1'b0);

    // Empty frame followed by a message
    send_msg(0, -1, -1, -1);
    fill_add_order();
    send_msg(36, -1, -1, -1);
    idle(2);
    chk("t5_count", bus.msg_count, 32'd7);

    // Reset in the middle of a body
    fill_pattern(8'h41, 36, 5);
    send_byte(8'h00);
    send_byte(8'h24);
    for (int i = 0; i < 10; i++) send_byte(body[i]);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    chk("t6_rst_count", bus.msg_count, 32'd0);
    chk("t6_rst_payload", bus.payload, '0);
    @(negedge clk) rst = 1'b0;
    idle(3);
    fill_add_order();
    send_msg(36, -1, -1, -1);
    idle(2);
    chk("t6_fresh_count", bus.msg_count, 32'd1);

    // Single-byte message
    body[0] = 8'h45;
    send_msg(1, -1, -1, -1);
    @(posedge clk); #2;
    one_byte = '0;
    one_byte[511:504] = 8'h45;
    chk("t7_payload", bus.payload, one_byte);
    chk("t7_pv", bus.payload_valid, 1'b1);
    idle(2);

    // Capacity boundary: exactly full, then one over
    fill_pattern(8'h52, 64, 1);
    send_msg(64, -1, -1, -1);
    fill_pattern(8'h52, 65, 2);
    send_msg(65, -1, -1, -1);
    idle(3);

    // Add order with the wrong length
    fill_pattern(8'h41, 32, 11);
    send_msg(32, -1, -1, -1);
    @(posedge clk); #2;
    chk("t8_pv", bus.payload_valid, 1'b1);
    chk("t8_len_err", bus.len_err, LCHK);
    chk("t8_aov", bus.add_order_valid, !LCHK);
    idle(5);

    chk("queue_drained", 512'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
